// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pkg
// Brief    : Shared types and constants for the instruction-fetch front end.
// Revision : 1.0
// ============================================================================
package fetch_pkg;

  localparam int ILEN     = 32;
  localparam int PC_INC   = 4;
  localparam int XLEN_DEF = 32;

  // Default queue entry for the 32-bit core; wider builds declare their own.
  typedef struct packed {
    logic [XLEN_DEF-1:0] pc;
    logic [ILEN-1:0]     instr;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_if
// Brief    : Memory request/response, redirect and decode channels of fetch.
// Revision : 1.0
// ============================================================================
interface fetch_if #(
  parameter int XLEN = 32
);
  import fetch_pkg::*;

  logic                 imem_req_valid;
  logic                 imem_req_ready;
  logic [XLEN-1:0]      imem_req_addr;
  logic                 imem_rsp_valid;
  logic [ILEN-1:0]      imem_rsp_data;
  logic                 redirect_valid;
  logic [XLEN-1:0]      redirect_pc;
  logic                 inst_valid;
  logic                 inst_ready;
  logic [ILEN-1:0]      inst_data;
  logic [XLEN-1:0]      inst_pc;
  logic [XLEN-1:0]      inst_pc_plus4;

  modport master (
    output imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc, inst_pc_plus4,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc,
           inst_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc, inst_pc_plus4,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc,
           inst_ready
  );

endinterface
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue
// Brief    : QDEPTH-entry in-order FIFO of fetched instructions; flush wins.
// Revision : 1.0
// ============================================================================
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int  QDEPTH  = 4,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        push,
  input  entry_t                      push_data,
  input  logic                        pop,
  input  logic                        flush,
  output entry_t                      head,
  output logic [$clog2(QDEPTH):0]     count,
  output logic                        empty
);

  localparam int c_ptr_w = $clog2(QDEPTH);
  localparam int c_cnt_w = c_ptr_w + 1;

  entry_t               r_mem [QDEPTH];
  logic [c_ptr_w-1:0]   r_wr_ptr;
  logic [c_ptr_w-1:0]   r_rd_ptr;
  logic [c_cnt_w-1:0]   r_count;
  logic                 w_do_pop;
  logic                 w_do_push;

  assign w_do_pop  = pop && (r_count != '0) && !flush;
  assign w_do_push = push && !flush && ((r_count != c_cnt_w'(QDEPTH)) || w_do_pop);

  // Storage is cleared so the decode-side outputs read zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < QDEPTH; i++) r_mem[i] <= '0;
    end else if (w_do_push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      r_count <= r_count + c_cnt_w'(w_do_push) - c_cnt_w'(w_do_pop);
    end
  end

  assign head  = r_mem[r_rd_ptr];
  assign count = r_count;
  assign empty = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Brief    : Decoupled PC / imem request / instruction-queue front end.
//            Define FETCH_PERF_EN to add the perf_fetched/perf_stall counters.
// Revision : 1.0
// ============================================================================
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              QDEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  fetch_if.master     bus
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall
`endif
);

  localparam int              c_cnt_w  = $clog2(QDEPTH) + 1;
  localparam int              c_sum_w  = c_cnt_w + 2;
  localparam logic [XLEN-1:0] c_pc_inc = XLEN'(PC_INC);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } entry_t;

  logic               r_run;
  logic [XLEN-1:0]    r_req_pc;
  logic [XLEN-1:0]    r_rsp_pc;
  logic [c_cnt_w-1:0] r_outstanding;
  logic [c_cnt_w-1:0] r_drop;

  logic [c_cnt_w-1:0] w_q_count;
  logic               w_q_empty;
  entry_t             w_head;
  entry_t             w_push_data;
  logic [c_sum_w-1:0] w_claims;
  logic               w_credit;
  logic               w_req_fire;
  logic               w_rsp_live;
  logic               w_push;
  logic               w_pop;
  logic [XLEN-1:0]    w_redirect_pc;

  // Every slot a request may eventually occupy is claimed up front, so a
  // returning response always finds room in the queue.
  assign w_claims   = c_sum_w'(r_outstanding) + c_sum_w'(r_drop) + c_sum_w'(w_q_count);
  assign w_credit   = r_run && (w_claims < c_sum_w'(QDEPTH));
  assign w_req_fire = w_credit && bus.imem_req_ready;

  assign w_rsp_live = bus.imem_rsp_valid && ((r_outstanding != '0) || (r_drop != '0));
  assign w_push     = bus.imem_rsp_valid && (r_drop == '0) && (r_outstanding != '0)
                      && !bus.redirect_valid;

  assign w_redirect_pc = {bus.redirect_pc[XLEN-1:2], 2'b00};
  assign w_push_data   = '{pc: r_rsp_pc, instr: bus.imem_rsp_data};

  assign bus.imem_req_valid = w_credit;
  assign bus.imem_req_addr  = r_req_pc;
  assign bus.inst_valid     = !w_q_empty && !bus.redirect_valid;
  assign bus.inst_data      = w_head.instr;
  assign bus.inst_pc        = w_head.pc;
  assign bus.inst_pc_plus4  = w_head.pc + c_pc_inc;
  assign w_pop              = bus.inst_valid && bus.inst_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run         <= 1'b0;
      r_req_pc      <= RESET_PC;
      r_rsp_pc      <= RESET_PC;
      r_outstanding <= '0;
      r_drop        <= '0;
    end else begin
      r_run <= 1'b1;
      if (bus.redirect_valid) begin
        r_req_pc      <= w_redirect_pc;
        r_rsp_pc      <= w_redirect_pc;
        r_outstanding <= '0;
        // Everything still in flight becomes stale, less a response retired now.
        r_drop        <= c_cnt_w'(c_sum_w'(r_drop) + c_sum_w'(r_outstanding)
                                  + c_sum_w'(w_req_fire) - c_sum_w'(w_rsp_live));
      end else begin
        if (w_req_fire) r_req_pc <= r_req_pc + c_pc_inc;
        if (w_push)     r_rsp_pc <= r_rsp_pc + c_pc_inc;
        r_outstanding <= r_outstanding + c_cnt_w'(w_req_fire) - c_cnt_w'(w_push);
        if (w_rsp_live && (r_drop != '0)) r_drop <= r_drop - c_cnt_w'(1);
      end
    end
  end

  fetch_queue #(
    .QDEPTH  (QDEPTH),
    .entry_t (entry_t)
  ) u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (w_push),
    .push_data (w_push_data),
    .pop       (w_pop),
    .flush     (bus.redirect_valid),
    .head      (w_head),
    .count     (w_q_count),
    .empty     (w_q_empty)
  );

`ifdef FETCH_PERF_EN
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_fetched <= '0;
      r_perf_stall   <= '0;
    end else begin
      if (w_pop && (r_perf_fetched != '1))
        r_perf_fetched <= r_perf_fetched + 32'd1;
      if (bus.inst_valid && !bus.inst_ready && (r_perf_stall != '1))
        r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign perf_fetched = r_perf_fetched;
  assign perf_stall   = r_perf_stall;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_stage
// Brief    : Directed + randomized bench for fetch_stage against a stream model.
// Revision : 1.0
// ============================================================================
module tb_fetch_stage;

  localparam int          QD   = 4;
  localparam logic [31:0] RPC  = 32'h100;

  logic clk;
  logic rst_n;

  fetch_if #(.XLEN(32)) bus ();

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
`endif

  fetch_stage #(.XLEN(32), .RESET_PC(RPC), .QDEPTH(QD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched (perf_fetched),
    .perf_stall   (perf_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } req_t;

  req_t        mem_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          epoch = 0;
  int          q_live = 0;
  int          lat = 1;
  int          accepts = 0;
  int          pops = 0;
  int          stalls = 0;
  bit          started = 0;
  logic [31:0] exp_req_pc = RPC;
  logic [31:0] exp_inst_pc = RPC;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h13579BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive at posedge+1, check at negedge, then advance the model.
  task automatic cycle(input bit redir, input logic [31:0] tgt, input bit req_rdy, input bit in_rdy);
    bit   rsp;
    bit   exp_rv;
    bit   exp_iv;
    req_t r;
    int   due;
    rsp = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
    bus.imem_req_ready = req_rdy;
    bus.inst_ready     = in_rdy;
    bus.redirect_valid = redir;
    bus.redirect_pc    = tgt;
    bus.imem_rsp_valid = rsp;
    bus.imem_rsp_data  = rsp ? mem_word(mem_q[0].addr) : $urandom;
    #4;
    exp_rv = started && ((mem_q.size() + q_live) < QD);
    exp_iv = (q_live > 0) && !redir;
    chk("req_valid", {31'b0, bus.imem_req_valid}, {31'b0, exp_rv});
    if (exp_rv) chk("req_addr", bus.imem_req_addr, exp_req_pc);
    chk("inst_valid", {31'b0, bus.inst_valid}, {31'b0, exp_iv});
    if (exp_iv) begin
      chk("inst_pc", bus.inst_pc, exp_inst_pc);
      chk("inst_data", bus.inst_data, mem_word(exp_inst_pc));
      chk("inst_pc_plus4", bus.inst_pc_plus4, exp_inst_pc + 32'd4);
    end
    if (exp_rv && req_rdy) begin
      due = cyc + lat;
      if (mem_q.size() > 0 && mem_q[mem_q.size()-1].due >= due) due = mem_q[mem_q.size()-1].due + 1;
      r.addr = exp_req_pc; r.epoch = epoch; r.due = due;
      mem_q.push_back(r);
      exp_req_pc += 32'd4;
      accepts++;
    end
    if (rsp) begin
      r = mem_q.pop_front();
      if (!redir && r.epoch == epoch) q_live++;
    end
    if (exp_iv && in_rdy) begin
      q_live--;
      exp_inst_pc += 32'd4;
      pops++;
    end
    if (exp_iv && !in_rdy) stalls++;
    if (redir) begin
      epoch++;
      q_live      = 0;
      exp_req_pc  = {tgt[31:2], 2'b00};
      exp_inst_pc = {tgt[31:2], 2'b00};
    end
    started = 1;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic reset_checks();
    chk("rst_req_valid", {31'b0, bus.imem_req_valid}, 32'd0);
    chk("rst_req_addr", bus.imem_req_addr, RPC);
    chk("rst_inst_valid", {31'b0, bus.inst_valid}, 32'd0);
    chk("rst_inst_data", bus.inst_data, 32'd0);
    chk("rst_inst_pc", bus.inst_pc, 32'd0);
    chk("rst_inst_pc_plus4", bus.inst_pc_plus4, 32'd4);
`ifdef FETCH_PERF_EN
    chk("rst_perf_fetched", perf_fetched, 32'd0);
    chk("rst_perf_stall", perf_stall, 32'd0);
`endif
  endtask

  task automatic quiet_inputs();
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.inst_ready     = 1'b0;
  endtask

  initial begin
    int a0;
    int p0;
    rst_n = 1'b0;
    quiet_inputs();
    #12;
    reset_checks();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Decode stalled: exactly QDEPTH requests, then fetch holds.
    lat = 1;
    a0 = accepts;
    repeat (12) cycle(1'b0, '0, 1'b1, 1'b0);
    chk("stall_reqs", accepts - a0, QD);
    repeat (20) cycle(1'b0, '0, 1'b1, 1'b1);

    // Zero-wait memory, decode always ready: one instruction per cycle.
    p0 = pops;
    repeat (20) cycle(1'b0, '0, 1'b1, 1'b1);
    chk("throughput", pops - p0, 20);

    // Three-cycle memory with requests in flight, then redirect.
    lat = 3;
    repeat (10) cycle(1'b0, '0, 1'b1, 1'b1);
    cycle(1'b1, 32'h200, 1'b1, 1'b1);
    repeat (12) cycle(1'b0, '0, 1'b1, 1'b1);

    // Redirect in steady state: response push and decode pop in the same cycle.
    lat = 1;
    repeat (6) cycle(1'b0, '0, 1'b1, 1'b1);
    cycle(1'b1, 32'h300, 1'b1, 1'b1);
    repeat (6) cycle(1'b0, '0, 1'b1, 1'b1);

    // Wrap at the top of the address space; low target bits ignored.
    cycle(1'b1, 32'hFFFF_FFFE, 1'b1, 1'b1);
    repeat (8) cycle(1'b0, '0, 1'b1, 1'b1);

    // Back-to-back redirects, last one wins.
    lat = 2;
    repeat (4) cycle(1'b0, '0, 1'b1, 1'b1);
    cycle(1'b1, 32'h400, 1'b1, 1'b1);
    cycle(1'b1, 32'h500, 1'b1, 1'b1);
    repeat (10) cycle(1'b0, '0, 1'b1, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      if (i % 100 == 0) lat = $urandom_range(1, 4);
      cycle(($urandom_range(0, 24) == 0), $urandom,
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0));
    end

    // Reset in mid-operation clears everything at once.
    rst_n = 1'b0;
    quiet_inputs();
    #4;
    reset_checks();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mem_q.delete();
    epoch++;
    q_live      = 0;
    started     = 0;
    exp_req_pc  = RPC;
    exp_inst_pc = RPC;
    pops        = 0;
    stalls      = 0;

    for (int i = 0; i < 300; i++) begin
      if (i % 50 == 0) lat = $urandom_range(1, 3);
      cycle(($urandom_range(0, 30) == 0), $urandom,
            ($urandom_range(0, 4) != 0), ($urandom_range(0, 2) != 0));
    end
    chk("some_delivered", {31'b0, (pops > 10)}, 32'd1);
`ifdef FETCH_PERF_EN
    chk("perf_fetched", perf_fetched, pops);
    chk("perf_stall", perf_stall, stalls);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
